vend_controller: RTL and testbench

- Downstream consumer of the credit register's Q output.
- Takes the accumulated credit and a product selection, and decides whether to dispense or deny.
- Times the dispense pulse and computes change.
- Issues a one-cycle clear back to the credit register's enter_in port, which zeroes the credit after a sale or refund.

---
 rtl/vend_controller.sv | 116 +++++++++++
 tb/tb_vend_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending controller: consumes the credit register's value, arbitrates buy/cancel,
// times the dispense pulse, computes change and pulses the credit clear.
module vend_controller #(
  parameter int              Width       = 8,
  parameter logic [Width:0]  PRICE0      = (Width+1)'(25),
  parameter logic [Width:0]  PRICE1      = (Width+1)'(50),
  parameter logic [Width:0]  PRICE2      = (Width+1)'(75),
  parameter logic [Width:0]  PRICE3      = (Width+1)'(100),
  parameter int              DISP_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [Width:0]   Credit,
  input  logic [1:0]       Sel,
  input  logic             Buy,
  input  logic             Cancel,
  output logic             Dispense,
  output logic [1:0]       ItemOut,
  output logic [Width:0]   Change,
  output logic             ChangeValid,
  output logic             ClrCredit,
  output logic             Insufficient,
  output logic             Busy
);

  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, CHANGE, DENY, REFUND} state_t;

  state_t         state;
  logic [7:0]     disp_cnt;
  logic [1:0]     sel_q;
  logic [Width:0] credit_q;
  logic [Width:0] price;
  logic           buy_d, cancel_d;
  logic           buy_rise, cancel_rise;

  assign buy_rise    = Buy & ~buy_d;
  assign cancel_rise = Cancel & ~cancel_d;

  // NOTE: price is assigned a default before the case so no latch is inferred.
  always_comb begin
    price = PRICE0;
    case (sel_q)
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      2'd3:    price = PRICE3;
      default: price = PRICE0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state        <= IDLE;
      disp_cnt     <= '0;
      sel_q        <= '0;
      credit_q     <= '0;
      // Edge history starts high so a button held through reset does not fire.
      buy_d        <= 1'b1;
      cancel_d     <= 1'b1;
      Dispense     <= 1'b0;
      ItemOut      <= '0;
      Change       <= '0;
      ChangeValid  <= 1'b0;
      ClrCredit    <= 1'b0;
      Insufficient <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      buy_d    <= Buy;
      cancel_d <= Cancel;

      // NOTE: outputs decode the current state with non-blocking assignments,
      // so they appear one cycle after the state they describe.
      Dispense     <= (state == DISPENSE);
      ItemOut      <= (state == DISPENSE) ? sel_q : 2'd0;
      ChangeValid  <= (state == CHANGE) || (state == REFUND);
      ClrCredit    <= (state == CHANGE) || (state == REFUND);
      Insufficient <= (state == DENY);
      Busy         <= (state != IDLE);

      case (state)
        IDLE: begin
          // Cancel takes priority; a cancel with no credit is simply dropped.
          if (cancel_rise) begin
            if (Credit != '0) begin
              Change <= Credit;
              state  <= REFUND;
            end
          end else if (buy_rise) begin
            sel_q    <= Sel;
            credit_q <= Credit;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (credit_q >= price) begin
            disp_cnt <= 8'(DISP_CYCLES - 1);
            state    <= DISPENSE;
          end else begin
            state <= DENY;
          end
        end
        DISPENSE: begin
          if (disp_cnt == 8'd0) state <= CHANGE;
          else                  disp_cnt <= disp_cnt - 8'd1;
        end
        CHANGE: begin
          Change <= credit_q - price;
          state  <= IDLE;
        end
        DENY:    state <= IDLE;
        REFUND:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller: records a window of output
// cycles after each stimulus and compares timing and values to hand-computed results.
module tb_vend_controller;

  logic       Clk = 1'b0;
  logic       Clr;
  logic [8:0] Credit;
  logic [1:0] Sel;
  logic       Buy, Cancel;
  logic       Dispense;
  logic [1:0] ItemOut;
  logic [8:0] Change;
  logic       ChangeValid, ClrCredit, Insufficient, Busy;

  vend_controller dut (
    .Clk(Clk), .Clr(Clr), .Credit(Credit), .Sel(Sel), .Buy(Buy), .Cancel(Cancel),
    .Dispense(Dispense), .ItemOut(ItemOut), .Change(Change), .ChangeValid(ChangeValid),
    .ClrCredit(ClrCredit), .Insufficient(Insufficient), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-window statistics; index i is the cycle after the i-th rising edge.
  int   n_disp, first_disp, n_cv, cv_idx, n_clr, n_insuf, insuf_idx, item_err, excl_err, n_busy;
  logic [8:0] cv_chg, last_chg;
  logic r_busy [32];
  logic r_zero [32];

  task automatic capture(input int n, input int rel_at, input int rebuy_at,
                         input int zero_at, input int clr_at, input logic [1:0] exp_item);
    n_disp = 0; first_disp = -1; n_cv = 0; cv_idx = -1; n_clr = 0;
    n_insuf = 0; insuf_idx = -1; item_err = 0; excl_err = 0; n_busy = 0;
    cv_chg = '0; last_chg = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      r_busy[i] = Busy;
      r_zero[i] = !Dispense && ItemOut == 2'd0 && Change == 9'd0 && !ChangeValid &&
                  !ClrCredit && !Insufficient && !Busy;
      if (Dispense) begin
        if (first_disp < 0) first_disp = i;
        n_disp++;
      end
      if (ItemOut !== (Dispense ? exp_item : 2'd0)) item_err++;
      if (ChangeValid) begin
        n_cv++;
        cv_idx = i;
        cv_chg = Change;
      end
      if (ClrCredit) n_clr++;
      if (Insufficient) begin
        n_insuf++;
        insuf_idx = i;
      end
      if (Busy) n_busy++;
      if ((ChangeValid && Insufficient) || (ClrCredit !== ChangeValid)) excl_err++;
      last_chg = Change;
      if (i == rel_at)   begin Buy = 1'b0; Cancel = 1'b0; end
      if (i == rebuy_at) Buy = 1'b1;
      if (i == zero_at)  Credit = 9'd0;
      if (i == clr_at)   Clr = 1'b1;
      if (i == clr_at + 1) Clr = 1'b0;
    end
  endtask

  initial begin
    Clr = 1'b1; Credit = '0; Sel = '0; Buy = 1'b0; Cancel = 1'b0;
    repeat (3) @(negedge Clk);
    Clr = 1'b0;
    repeat (2) @(negedge Clk);

    // Reset state
    check("rst_dispense", Dispense, 0);
    check("rst_itemout",  ItemOut, 0);
    check("rst_change",   Change, 0);
    check("rst_cv",       ChangeValid, 0);
    check("rst_clr",      ClrCredit, 0);
    check("rst_insuf",    Insufficient, 0);
    check("rst_busy",     Busy, 0);

    // Exact pay, Buy held for the whole window: one purchase only
    Credit = 9'd50; Sel = 2'd1; Buy = 1'b1;
    capture(12, -1, -1, -1, -1, 2'd1);
    check("exact_first_disp", first_disp, 2);
    check("exact_n_disp",     n_disp, 4);
    check("exact_item",       item_err, 0);
    check("exact_n_cv",       n_cv, 1);
    check("exact_cv_idx",     cv_idx, 6);
    check("exact_change",     cv_chg, 0);
    check("exact_n_clr",      n_clr, 1);
    check("exact_busy_mid",   r_busy[3], 1);
    check("exact_busy_end",   r_busy[11], 0);
    check("exact_insuf",      n_insuf, 0);
    check("exact_excl",       excl_err, 0);
    Buy = 1'b0;
    @(negedge Clk);

    // Overpay: 120 - 75 = 45
    Credit = 9'd120; Sel = 2'd2; Buy = 1'b1;
    capture(10, 0, -1, -1, -1, 2'd2);
    check("over_first_disp", first_disp, 2);
    check("over_n_disp",     n_disp, 4);
    check("over_item",       item_err, 0);
    check("over_cv_idx",     cv_idx, 6);
    check("over_change",     cv_chg, 45);
    check("over_n_clr",      n_clr, 1);
    check("over_excl",       excl_err, 0);

    // Rebuy and credit drop during DISPENSE: latched 100 - 25 = 75
    Credit = 9'd100; Sel = 2'd0; Buy = 1'b1;
    capture(12, 0, 2, 2, -1, 2'd0);
    check("stab_n_disp", n_disp, 4);
    check("stab_n_cv",   n_cv, 1);
    check("stab_cv_idx", cv_idx, 6);
    check("stab_change", cv_chg, 75);
    check("stab_item",   item_err, 0);
    Buy = 1'b0;
    @(negedge Clk);

    // Insufficient: 90 < 100
    Credit = 9'd90; Sel = 2'd3; Buy = 1'b1;
    capture(8, 0, -1, -1, -1, 2'd0);
    check("insuf_idx",    insuf_idx, 2);
    check("insuf_n",      n_insuf, 1);
    check("insuf_disp",   n_disp, 0);
    check("insuf_clr",    n_clr, 0);
    check("insuf_cv",     n_cv, 0);
    check("insuf_change", last_chg, 75);
    check("insuf_excl",   excl_err, 0);

    // Cancel and Buy together: Cancel wins, refund 30
    Credit = 9'd30; Sel = 2'd1; Buy = 1'b1; Cancel = 1'b1;
    capture(6, 0, -1, -1, -1, 2'd0);
    check("refund_cv_idx", cv_idx, 1);
    check("refund_change", cv_chg, 30);
    check("refund_n_clr",  n_clr, 1);
    check("refund_disp",   n_disp, 0);
    check("refund_insuf",  n_insuf, 0);

    // Cancel with zero credit: nothing happens
    Credit = 9'd0; Cancel = 1'b1;
    capture(6, 0, -1, -1, -1, 2'd0);
    check("cancel0_cv",     n_cv, 0);
    check("cancel0_clr",    n_clr, 0);
    check("cancel0_busy",   n_busy, 0);
    check("cancel0_disp",   n_disp, 0);
    check("cancel0_change", last_chg, 30);

    // Clr during the second Dispense cycle
    Credit = 9'd50; Sel = 2'd1; Buy = 1'b1;
    capture(10, 0, -1, -1, 3, 2'd1);
    check("clr_n_disp", n_disp, 2);
    check("clr_zero",   r_zero[4], 1);
    check("clr_cv",     n_cv, 0);
    check("clr_clr",    n_clr, 0);
    check("clr_busy",   n_busy, 3);

    // Buy held across reset release: no purchase
    Credit = 9'd100; Sel = 2'd0; Buy = 1'b1; Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    capture(10, -1, -1, -1, -1, 2'd0);
    check("held_disp", n_disp, 0);
    check("held_busy", n_busy, 0);
    check("held_cv",   n_cv, 0);
    Buy = 1'b0;
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
